clock_core: RTL and testbench
=============================

// Module: clock_core
// PURPOSE
//  Time-keeping core of the alarm clock: consumes clock_op_t strobes from the button/control stage.
//  Keeps HH:MM:SS time, an HH:MM alarm, the current mode, edit cursor, alarm enable and ringing state.
//  Feeds the LCD display stage with the values to show and raises alarm_ring_o.
// PARAMETERS
//  CLOCK_FREQ    CLOCK_FREQ_DEFAULT (2)  clk cycles per second tick; must be >= 1
//  RING_SECONDS  60                      auto-silence timeout in seconds; must be >= 1
// PORTS
//  clk            in   1   system clock
//  rst_n          in   1   asynchronous, active-low reset
//  op_i           in   6   clock_op_t strobes; each set bit is acted on once per cycle it is high
//  disp_hours_o   out  5   hours to display, 0..23 (alarm hours in SET_ALARM, else time)
//  disp_minutes_o out  6   minutes to display, 0..59 (alarm minutes in SET_ALARM, else time)
//  disp_seconds_o out  6   time seconds, 0..59 (always the time value)
//  mode_o         out  2   clock_mode_t current mode
//  cursor_o       out  1   cursor_t: 0 = HOURS, 1 = MINUTES
//  alarm_en_o     out  1   alarm armed
//  alarm_ring_o   out  1   alarm ringing
// BEHAVIOUR
//  Reset (async, rst_n=0): time 00:00:00, alarm 00:00, mode MODE_DISPLAY, cursor HOURS,
//   alarm_en_o=0, alarm_ring_o=0, prescaler=0, ring counter=0. All outputs registered or muxed from registers.
//  Prescaler: counts 0..CLOCK_FREQ-1; sec_tick=1 in the cycle count==CLOCK_FREQ-1, then wraps to 0.
//   Held at 0 while mode==MODE_SET_TIME.
//  Time advance on sec_tick: ss 59->0 carries to mm; mm 59->0 carries to hh; 23:59:59 -> 00:00:00.
//   Runs in MODE_DISPLAY and MODE_SET_ALARM; frozen in MODE_SET_TIME.
//  Op priority when several bits are set in one cycle: display_time > set_time > set_alarm >
//   toggle_alarm > left > up; only the highest set bit is acted on, the others are dropped.
//  Mode transitions (from any mode; the cursor is reset to HOURS on every mode op):
//   - display_time -> MODE_DISPLAY.
//   - set_time -> MODE_SET_TIME; seconds cleared to 0 and prescaler cleared in the same edge.
//   - set_alarm -> MODE_SET_ALARM.
//  toggle_alarm: flips alarm_en in any mode; when disabling, alarm_ring_o clears in the same edge.
//  left: toggles the cursor in the two set modes; ignored in MODE_DISPLAY.
//  up, in the two set modes only; ignored in MODE_DISPLAY:
//   - cursor HOURS: selected hh += 1 mod 24.
//   - cursor MINUTES: selected mm += 1 mod 60, with no carry into hours.
//   - MODE_SET_TIME edits the time; MODE_SET_ALARM edits the alarm.
//   - In MODE_SET_ALARM an up and a sec_tick in the same cycle both take effect (different registers).
//  Alarm match: on a sec_tick edge whose next time is alarm_hh:alarm_mm:00 with alarm_en=1,
//   alarm_ring_o rises on the following edge (1-cycle latency).
//   - Editing time onto the alarm value never rings; no match is possible in MODE_SET_TIME.
//  Ringing:
//   - Ring counter is cleared when ringing starts and counts sec_ticks.
//   - Ringing clears on the first edge where any op_i bit is set (the op is also executed),
//     or when alarm_en clears, or after RING_SECONDS sec_ticks.
//   - A match while already ringing restarts the counter.
//  Reset mid-operation: returns immediately to reset values; a ring in progress is lost.
// STRUCTURE
//  common_pkg additions: clock_mode_t enum {MODE_DISPLAY, MODE_SET_TIME, MODE_SET_ALARM} (2 bits);
//   cursor_t enum {CUR_HOURS, CUR_MINUTES}; localparam RING_SECONDS_DEFAULT=60.
//  Sub-module sec_prescaler (CLOCK_FREQ; clk, rst_n, hold_i, tick_o) produces sec_tick.
//  The remainder of the core is a single always_ff block with next-state logic, plus a comb display mux.
// TESTING (CLOCK_FREQ=2 unless noted)
//  1 Reset, then 86400 sec_ticks -> time wraps 23:59:59 -> 00:00:00 exactly on the 86400th tick;
//    disp_seconds_o steps once every 2 clks.
//  2 set_time, up x13, left, up x61, display_time -> 13:01:00; time stays frozen while in SET_TIME;
//    cursor_o==HOURS after each mode op.
//  3 set_alarm, up x7, left, up x30, display_time, toggle_alarm; time preset 07:29:58
//    -> alarm_ring_o=1 one clk after the time reads 07:30:00.
//  4 While ringing, a left pulse -> ring clears next edge; a separate run with no op
//    -> ring clears after 60 sec_ticks (RING_SECONDS=60).
//  5 op_i with set_time|up|left set in one cycle -> only set_time acts: mode=SET_TIME, hh/mm unchanged, cursor HOURS.
//  6 rst_n asserted mid-ring and mid-SET_ALARM edit -> all outputs at reset values asynchronously, before the next clk edge.

Source files
------------

// File: rtl/clock_core_pkg.sv
// Shared types for the alarm-clock time-keeping core: modes, cursor, op strobes and
// small modular-increment helpers.
package clock_core_pkg;

  localparam int CLOCK_FREQ_DEFAULT   = 2;
  localparam int RING_SECONDS_DEFAULT = 60;

  typedef enum logic [1:0] {
    MODE_DISPLAY   = 2'd0,
    MODE_SET_TIME  = 2'd1,
    MODE_SET_ALARM = 2'd2
  } clock_mode_t;

  typedef enum logic {
    CUR_HOURS   = 1'b0,
    CUR_MINUTES = 1'b1
  } cursor_t;

  // One strobe per bit; a higher bit index means a higher priority.
  typedef logic [5:0] clock_op_t;
  localparam int OP_UP           = 0;
  localparam int OP_LEFT         = 1;
  localparam int OP_TOGGLE_ALARM = 2;
  localparam int OP_SET_ALARM    = 3;
  localparam int OP_SET_TIME     = 4;
  localparam int OP_DISPLAY_TIME = 5;

  typedef enum logic [2:0] {
    ACT_NONE, ACT_DISPLAY, ACT_SET_TIME, ACT_SET_ALARM, ACT_TOGGLE, ACT_LEFT, ACT_UP
  } op_act_t;

  function automatic op_act_t decode_op(input clock_op_t op);
    if      (op[OP_DISPLAY_TIME]) return ACT_DISPLAY;
    else if (op[OP_SET_TIME])     return ACT_SET_TIME;
    else if (op[OP_SET_ALARM])    return ACT_SET_ALARM;
    else if (op[OP_TOGGLE_ALARM]) return ACT_TOGGLE;
    else if (op[OP_LEFT])         return ACT_LEFT;
    else if (op[OP_UP])           return ACT_UP;
    else                          return ACT_NONE;
  endfunction

  function automatic logic [4:0] inc_hours(input logic [4:0] h);
    return (h == 5'd23) ? 5'd0 : h + 5'd1;
  endfunction

  function automatic logic [5:0] inc_sixty(input logic [5:0] v);
    return (v == 6'd59) ? 6'd0 : v + 6'd1;
  endfunction

endpackage

// File: rtl/clock_core_sec_prescaler.sv
// Divides clk down to a one-cycle sec_tick strobe; hold_i parks the count at zero.
module sec_prescaler #(
  parameter int CLOCK_FREQ = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic hold_i,
  output logic tick_o
);

  localparam int CW = (CLOCK_FREQ > 1) ? $clog2(CLOCK_FREQ) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLOCK_FREQ - 1);

  logic [CW-1:0] cnt_q;

  assign tick_o = (cnt_q == LAST) && !hold_i;

  // NOTE: sequential state is always written with <= so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (hold_i || cnt_q == LAST) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

endmodule

// File: rtl/clock_core.sv
// Alarm-clock time-keeping core: HH:MM:SS time, HH:MM alarm, mode/cursor editing and
// the ringing state, with a display mux selecting alarm or time for the LCD stage.
module clock_core
  import clock_core_pkg::*;
#(
  parameter int CLOCK_FREQ   = CLOCK_FREQ_DEFAULT,
  parameter int RING_SECONDS = RING_SECONDS_DEFAULT
) (
  input  logic       clk,
  input  logic       rst_n,
  input  clock_op_t  op_i,
  output logic [4:0] disp_hours_o,
  output logic [5:0] disp_minutes_o,
  output logic [5:0] disp_seconds_o,
  output logic [1:0] mode_o,
  output logic       cursor_o,
  output logic       alarm_en_o,
  output logic       alarm_ring_o
);

  localparam int RW = $clog2(RING_SECONDS + 1);

  logic [4:0]  hh_q, hh_d, alarm_hh_q, alarm_hh_d;
  logic [5:0]  mm_q, mm_d, ss_q, ss_d, alarm_mm_q, alarm_mm_d;
  clock_mode_t mode_q, mode_d;
  cursor_t     cursor_q, cursor_d;
  logic        alarm_en_q, alarm_en_d, ring_q, ring_d, match_q, match_d;
  logic [RW-1:0] ring_cnt_q, ring_cnt_d;

  op_act_t act;
  logic    sec_tick;

  assign act = decode_op(op_i);

  // Entering SET_TIME clears the prescaler on the same edge that clears seconds.
  sec_prescaler #(.CLOCK_FREQ(CLOCK_FREQ)) u_prescaler (
    .clk    (clk),
    .rst_n  (rst_n),
    .hold_i ((mode_q == MODE_SET_TIME) || (act == ACT_SET_TIME)),
    .tick_o (sec_tick)
  );

  // NOTE: every signal assigned here gets a default first, so no latch is inferred.
  always_comb begin
    hh_d       = hh_q;
    mm_d       = mm_q;
    ss_d       = ss_q;
    alarm_hh_d = alarm_hh_q;
    alarm_mm_d = alarm_mm_q;
    mode_d     = mode_q;
    cursor_d   = cursor_q;
    alarm_en_d = alarm_en_q;
    ring_d     = ring_q;
    ring_cnt_d = ring_cnt_q;

    if (sec_tick) begin
      ss_d = inc_sixty(ss_q);
      if (ss_q == 6'd59) begin
        mm_d = inc_sixty(mm_q);
        if (mm_q == 6'd59) hh_d = inc_hours(hh_q);
      end
    end

    // Only the tick path can produce a match, so time edits never ring.
    match_d = sec_tick && alarm_en_q && (hh_d == alarm_hh_q) &&
              (mm_d == alarm_mm_q) && (ss_d == 6'd0);

    if (ring_q && sec_tick) begin
      ring_cnt_d = ring_cnt_q + 1'b1;
      if (ring_cnt_d == RW'(RING_SECONDS)) ring_d = 1'b0;
    end
    if (match_q && alarm_en_q) begin
      ring_d     = 1'b1;
      ring_cnt_d = '0;
    end
    if (ring_q && |op_i) ring_d = 1'b0;

    case (act)
      ACT_DISPLAY: begin
        mode_d   = MODE_DISPLAY;
        cursor_d = CUR_HOURS;
      end
      ACT_SET_TIME: begin
        mode_d   = MODE_SET_TIME;
        cursor_d = CUR_HOURS;
        ss_d     = 6'd0;
      end
      ACT_SET_ALARM: begin
        mode_d   = MODE_SET_ALARM;
        cursor_d = CUR_HOURS;
      end
      ACT_TOGGLE: begin
        alarm_en_d = !alarm_en_q;
        if (alarm_en_q) ring_d = 1'b0;
      end
      ACT_LEFT: begin
        if (mode_q != MODE_DISPLAY) cursor_d = cursor_t'(~cursor_q);
      end
      ACT_UP: begin
        if (mode_q == MODE_SET_TIME) begin
          if (cursor_q == CUR_HOURS) hh_d = inc_hours(hh_q);
          else                       mm_d = inc_sixty(mm_q);
        end else if (mode_q == MODE_SET_ALARM) begin
          if (cursor_q == CUR_HOURS) alarm_hh_d = inc_hours(alarm_hh_q);
          else                       alarm_mm_d = inc_sixty(alarm_mm_q);
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hh_q       <= '0;
      mm_q       <= '0;
      ss_q       <= '0;
      alarm_hh_q <= '0;
      alarm_mm_q <= '0;
      mode_q     <= MODE_DISPLAY;
      cursor_q   <= CUR_HOURS;
      alarm_en_q <= 1'b0;
      ring_q     <= 1'b0;
      match_q    <= 1'b0;
      ring_cnt_q <= '0;
    end else begin
      hh_q       <= hh_d;
      mm_q       <= mm_d;
      ss_q       <= ss_d;
      alarm_hh_q <= alarm_hh_d;
      alarm_mm_q <= alarm_mm_d;
      mode_q     <= mode_d;
      cursor_q   <= cursor_d;
      alarm_en_q <= alarm_en_d;
      ring_q     <= ring_d;
      match_q    <= match_d;
      ring_cnt_q <= ring_cnt_d;
    end
  end

  always_comb begin
    disp_hours_o   = (mode_q == MODE_SET_ALARM) ? alarm_hh_q : hh_q;
    disp_minutes_o = (mode_q == MODE_SET_ALARM) ? alarm_mm_q : mm_q;
  end

  assign disp_seconds_o = ss_q;
  assign mode_o         = mode_q;
  assign cursor_o       = cursor_q;
  assign alarm_en_o     = alarm_en_q;
  assign alarm_ring_o   = ring_q;

endmodule

// File: tb/tb_clock_core.sv
// Directed bench for clock_core (CLOCK_FREQ=2, RING_SECONDS=60): editing, wrap, alarm, ring and reset.
module tb_clock_core;
  import clock_core_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n;
  clock_op_t  op_i;
  logic [4:0] disp_hours_o;
  logic [5:0] disp_minutes_o, disp_seconds_o;
  logic [1:0] mode_o;
  logic       cursor_o, alarm_en_o, alarm_ring_o;

  int checks   = 0;
  int failures = 0;

  localparam clock_op_t B_UP   = 6'b000001;
  localparam clock_op_t B_LEFT = 6'b000010;
  localparam clock_op_t B_TOG  = 6'b000100;
  localparam clock_op_t B_SALM = 6'b001000;
  localparam clock_op_t B_STIM = 6'b010000;
  localparam clock_op_t B_DISP = 6'b100000;

  always #5 clk = ~clk;

  clock_core #(.CLOCK_FREQ(2), .RING_SECONDS(60)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .op_i           (op_i),
    .disp_hours_o   (disp_hours_o),
    .disp_minutes_o (disp_minutes_o),
    .disp_seconds_o (disp_seconds_o),
    .mode_o         (mode_o),
    .cursor_o       (cursor_o),
    .alarm_en_o     (alarm_en_o),
    .alarm_ring_o   (alarm_ring_o)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_time(input string tag, input int h, input int m, input int s);
    check({tag, ".hh"}, 32'(disp_hours_o), h);
    check({tag, ".mm"}, 32'(disp_minutes_o), m);
    check({tag, ".ss"}, 32'(disp_seconds_o), s);
  endtask

  task automatic clks(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse(input clock_op_t v);
    op_i = v;
    @(posedge clk);
    #1;
    op_i = '0;
  endtask

  task automatic pulses(input clock_op_t v, input int n);
    repeat (n) pulse(v);
  endtask

  initial begin
    rst_n = 1'b0;
    op_i  = '0;
    #12;
    check_time("reset", 0, 0, 0);
    check("reset.mode", 32'(mode_o), 0);
    check("reset.cursor", 32'(cursor_o), 0);
    check("reset.alarm_en", 32'(alarm_en_o), 0);
    check("reset.ring", 32'(alarm_ring_o), 0);
    rst_n = 1'b1;

    // Seconds step once every two clocks.
    clks(1); check("step.e1", 32'(disp_seconds_o), 0);
    clks(1); check("step.e2", 32'(disp_seconds_o), 1);
    clks(1); check("step.e3", 32'(disp_seconds_o), 1);
    clks(1); check("step.e4", 32'(disp_seconds_o), 2);

    // Time setting to 13:01:00, frozen while editing.
    pulse(B_STIM);
    check("stime.mode", 32'(mode_o), 1);
    check("stime.cursor", 32'(cursor_o), 0);
    check("stime.ss", 32'(disp_seconds_o), 0);
    pulses(B_UP, 13);
    clks(5);
    check("stime.hh13", 32'(disp_hours_o), 13);
    check("stime.frozen", 32'(disp_seconds_o), 0);
    pulse(B_LEFT);
    check("stime.cursor_min", 32'(cursor_o), 1);
    pulses(B_UP, 61);
    pulse(B_DISP);
    check("disp.mode", 32'(mode_o), 0);
    check("disp.cursor", 32'(cursor_o), 0);
    check_time("set1301", 13, 1, 0);

    // Priority: set_time beats up and left.
    clks(3);
    pulse(B_STIM | B_UP | B_LEFT);
    check("prio.mode", 32'(mode_o), 1);
    check("prio.cursor", 32'(cursor_o), 0);
    check_time("prio", 13, 1, 0);

    // Day wrap from 23:59:59.
    pulses(B_UP, 10);
    pulse(B_LEFT);
    pulses(B_UP, 58);
    pulse(B_DISP);
    check_time("set2359", 23, 59, 0);
    clks(118); check_time("pre_wrap", 23, 59, 59);
    clks(1);   check_time("pre_wrap_hold", 23, 59, 59);
    clks(1);   check_time("wrap", 0, 0, 0);

    // Alarm 07:30 set while the time keeps running.
    pulse(B_SALM);
    check("salm.mode", 32'(mode_o), 2);
    check("salm.cursor", 32'(cursor_o), 0);
    pulses(B_UP, 7);
    pulse(B_LEFT);
    pulses(B_UP, 30);
    check_time("salm", 7, 30, 19);
    pulse(B_DISP);
    check("salm.back_hh", 32'(disp_hours_o), 0);
    check("salm.back_mm", 32'(disp_minutes_o), 0);
    pulse(B_TOG);
    check("alarm_en", 32'(alarm_en_o), 1);

    // Ring 1: auto-silence after 60 seconds.
    pulse(B_STIM);
    pulses(B_UP, 7);
    pulse(B_LEFT);
    pulses(B_UP, 29);
    pulse(B_DISP);
    check_time("set0729", 7, 29, 0);
    clks(116); check_time("t0729_58", 7, 29, 58);
    clks(4);   check_time("t0730", 7, 30, 0);
    check("ring.latency0", 32'(alarm_ring_o), 0);
    clks(1);   check("ring.rise", 32'(alarm_ring_o), 1);
    clks(118); check("ring.last", 32'(alarm_ring_o), 1);
    clks(1);   check("ring.timeout", 32'(alarm_ring_o), 0);
    check_time("t0731", 7, 31, 0);

    // Ring 2: any op silences it on its edge.
    pulse(B_STIM);
    pulse(B_LEFT);
    pulses(B_UP, 58);
    pulse(B_DISP);
    check_time("reset0729", 7, 29, 0);
    clks(121); check("ring2.rise", 32'(alarm_ring_o), 1);
    clks(3);   check("ring2.hold", 32'(alarm_ring_o), 1);
    pulse(B_LEFT);
    check("ring2.left_clear", 32'(alarm_ring_o), 0);
    check("ring2.cursor", 32'(cursor_o), 0);
    check("ring2.mode", 32'(mode_o), 0);
    check("ring2.alarm_en", 32'(alarm_en_o), 1);

    // Ring 3, then asynchronous reset mid-ring.
    pulse(B_STIM);
    pulse(B_LEFT);
    pulses(B_UP, 59);
    pulse(B_DISP);
    check_time("third0729", 7, 29, 0);
    clks(121); check("ring3.rise", 32'(alarm_ring_o), 1);
    rst_n = 1'b0;
    #1;
    check("arst.ring", 32'(alarm_ring_o), 0);
    check("arst.alarm_en", 32'(alarm_en_o), 0);
    check("arst.mode", 32'(mode_o), 0);
    check_time("arst", 0, 0, 0);
    #2;
    rst_n = 1'b1;
    clks(1);

    // Asynchronous reset mid alarm edit.
    pulse(B_SALM);
    pulses(B_UP, 3);
    pulse(B_LEFT);
    check("edit.mode", 32'(mode_o), 2);
    check("edit.hh", 32'(disp_hours_o), 3);
    check("edit.cursor", 32'(cursor_o), 1);
    rst_n = 1'b0;
    #1;
    check("arst2.mode", 32'(mode_o), 0);
    check("arst2.cursor", 32'(cursor_o), 0);
    check("arst2.hh", 32'(disp_hours_o), 0);
    check("arst2.mm", 32'(disp_minutes_o), 0);
    #2;
    rst_n = 1'b1;
    clks(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
